ram_upload: RTL and testbench
=============================

Name: ram_upload

Overview:
- Core-to-HPS counterpart of the ROM/boot download path: serves HPS ioctl upload read requests by fetching bytes from SDRAM, so main RAM can be saved as a snapshot.
- Sits beside hps_io and the sdram controller.
- While an upload is active it owns the SDRAM request port through the top-level reset mux, the same way the boot writer does, and holds the CPC core in reset.
- Keeps a running checksum of every byte served.

Parameters:
UP_INDEX, 8'd1, ioctl_index value that selects this uploader
RAM_BASE, 23'h200000, SDRAM byte address that maps to upload offset 0
SIZE_LOG2, 17, upload image size is 2^SIZE_LOG2 bytes (128 KB)
LAT_REFS, 2, ce_ref periods from read issue to data sample (1..3)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
ce_ref  in  1  SDRAM cycle strobe, one clk_sys every 16
ioctl_upload  in  1  HPS upload session active
ioctl_index  in  8  HPS file index
ioctl_rd  in  1  one-cycle byte read request
ioctl_addr  in  25  byte offset requested
ioctl_din  out  8  byte returned to HPS
ioctl_wait  out  1  high while the byte is not yet valid
ram_oe  out  1  SDRAM read request (muxed into sdram oe)
ram_a  out  23  SDRAM byte address
ram_bank  out  2  SDRAM bank
ram_dout  in  8  SDRAM read data
bank_sel  in  2  bank to dump, latched at session start
hold_reset  out  1  keep the CPC core in reset
busy  out  1  fetch in progress
err  out  1  sticky: ioctl_rd seen while busy
sum  out  8  modulo-256 sum of the bytes served this session

Behaviour:
- Reset values: all outputs 0, except ioctl_din = 8'hFF. State is IDLE.
- Session active: act = ioctl_upload & (ioctl_index == UP_INDEX).
  - hold_reset = act, registered; it follows act one cycle later.
  - On the rising edge of act: latch bank_sel into ram_bank, clear sum and err.
- FSM states: IDLE, PEND, FETCH.
  - IDLE: on act & ioctl_rd:
    - In range (ioctl_addr[24:SIZE_LOG2] == 0): ram_a <= RAM_BASE + ioctl_addr[SIZE_LOG2-1:0] (23-bit add, carry discarded). ioctl_wait <= 1, busy <= 1. Go to PEND.
    - Out of range: ioctl_din <= 8'hFF the next cycle. No wait, no SDRAM access, sum unchanged.
  - PEND: on ce_ref, ram_oe <= 1, load the ce_ref counter with LAT_REFS. Go to FETCH.
  - FETCH: decrement the counter on each ce_ref. In the cycle where the counter reaches 0 on ce_ref:
    - ioctl_din <= ram_dout
    - sum <= sum + ram_dout
    - ram_oe <= 0, ioctl_wait <= 0, busy <= 0
    - Go to IDLE.
- Latency: ioctl_wait is high from the cycle after ioctl_rd. Worst case it drops 16*(LAT_REFS+1) clk_sys later.
- ioctl_rd while busy: ignored, err <= 1 (sticky until the next session start or reset), the fetch in flight continues.
- act falls mid-fetch: abort to IDLE the same cycle. ram_oe, ioctl_wait and busy go to 0; ioctl_din and sum are unchanged.
- reset mid-fetch: identical to reset values, applied in the next cycle.
- ce_ref in the same cycle as ioctl_rd in IDLE: that ce_ref is not used. Issue happens on the next ce_ref in PEND.
- ram_a is stable whenever ram_oe = 1.

Decomposition:
- Shared package cpc_io_pkg:
  - localparams UP_INDEX_SNAP, RAM_BASE_MAIN
  - typedef enum logic [1:0] {UP_IDLE, UP_PEND, UP_FETCH}
- One sub-module is natural: ref_delay, the LAT_REFS ce_ref down-counter with a done pulse.
- Everything else stays in ram_upload.

Test Plan:
- Preload SDRAM model with 8'hA5 at 23'h200000, act, ioctl_rd at ioctl_addr 0 with LAT_REFS=2 -> ram_oe high for exactly 2 ce_ref periods, ram_a=23'h200000, ioctl_din=8'hA5, ioctl_wait low within 48 clk_sys, sum=8'hA5.
- Read offsets 25'h1FFFF and 25'h20000 -> first issues ram_a=23'h21FFFF; second returns 8'hFF with no wait pulse and ram_oe never high.
- Session of 4 reads of bytes 8'h80, 8'h80, 8'h01, 8'hFF -> sum=8'h00 (wrap-around); new session start -> sum=0.
- Second ioctl_rd 3 cycles after the first -> err=1, only one SDRAM read, ioctl_din equals the first byte.
- Drop ioctl_upload during FETCH -> next cycle ram_oe=0, ioctl_wait=0, state IDLE; hold_reset falls one cycle after act.
- Assert reset during PEND -> ioctl_din=8'hFF, all other outputs 0, no ram_oe pulse afterwards.

Source files
------------

// File: rtl/cpc_io_pkg.sv
// Shared CPC I/O types and constants for the HPS upload/download paths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpc_io_pkg;

   // ioctl_index value that selects the main-RAM snapshot upload
   localparam logic [7:0]  UP_INDEX_SNAP = 8'd1;

   // SDRAM byte address of main RAM (upload offset 0)
   localparam logic [22:0] RAM_BASE_MAIN = 23'h200000;

   // Uploader FSM: waiting for a request, waiting for an SDRAM slot, fetching
   typedef enum logic [1:0] {
      UP_IDLE,
      UP_PEND,
      UP_FETCH
   } up_state_t;

endpackage

// File: rtl/ram_upload_if.sv
// HPS ioctl upload port plus the SDRAM read port owned by the uploader.
// Latency: none (wiring only).
// Backpressure: ioctl_wait stalls the HPS until the requested byte is valid.
interface ram_upload_if;

   logic        ioctl_upload;
   logic [7:0]  ioctl_index;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;

   logic        ram_oe;
   logic [22:0] ram_a;
   logic [1:0]  ram_bank;
   logic [7:0]  ram_dout;

   // HPS / SDRAM side: issues read requests, supplies SDRAM data
   modport master (
      output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_dout,
      input  ioctl_din, ioctl_wait, ram_oe, ram_a, ram_bank
   );

   // Uploader side: serves read requests, drives the SDRAM read port
   modport slave (
      input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, ram_dout,
      output ioctl_din, ioctl_wait, ram_oe, ram_a, ram_bank
   );

endinterface

// File: rtl/ref_delay.sv
// Counts LAT_REFS ce_ref strobes after a load and pulses done on the last one.
// Latency: done is combinational on the LAT_REFS-th ce_ref seen while run is high.
// Backpressure: none; run gates counting, a new load restarts the count.
module ref_delay #(
   parameter int LAT_REFS = 2
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ce_ref,
   input  logic load,
   input  logic run,
   output logic done
);

   logic [1:0] cnt;

   // Reload on issue, then count ce_ref periods down while fetching
   always_ff @(posedge clk_sys) begin
      if (reset)
         cnt <= 2'd0;
      else if (load)
         cnt <= 2'(LAT_REFS);
      else if (run && ce_ref && cnt != 2'd0)
         cnt <= cnt - 2'd1;
   end

   // The strobe that takes the counter from 1 to 0 is the data sample point
   assign done = run & ce_ref & (cnt == 2'd1);

endmodule

// File: rtl/ram_upload.sv
// Serves HPS ioctl upload byte reads from SDRAM and sums the bytes served.
// Latency: in-range byte valid at most 16*(LAT_REFS+1) clk_sys after ioctl_rd.
// Backpressure: ioctl_wait holds the HPS off; reads arriving while busy are dropped and flagged.
module ram_upload
   import cpc_io_pkg::*;
#(
   parameter logic [7:0]  UP_INDEX  = UP_INDEX_SNAP,
   parameter logic [22:0] RAM_BASE  = RAM_BASE_MAIN,
   parameter int          SIZE_LOG2 = 17,
   parameter int          LAT_REFS  = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_ref,
   ram_upload_if.slave io,
   input  logic [1:0]  bank_sel,
   output logic        hold_reset,
   output logic        busy,
   output logic        err,
   output logic [7:0]  sum
);

   up_state_t state, nxt_state;

   logic act, act_rise, in_range, rd_req;
   logic accept, reject, issue, finish, abort, overlap;
   logic run, done;

   // A session is only ours when the HPS selects our file index
   assign act      = io.ioctl_upload & (io.ioctl_index == UP_INDEX);
   // hold_reset is act delayed by one cycle, so it doubles as the edge detector
   assign act_rise = act & ~hold_reset;
   assign in_range = (io.ioctl_addr[24:SIZE_LOG2] == '0);
   assign rd_req   = act & io.ioctl_rd;

   ref_delay #(
      .LAT_REFS (LAT_REFS)
   ) u_ref_delay (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce_ref  (ce_ref),
      .load    (issue),
      .run     (run),
      .done    (done)
   );

   // State register
   always_ff @(posedge clk_sys) begin
      if (reset)
         state <= UP_IDLE;
      else
         state <= nxt_state;
   end

   // Next state; losing the session aborts from any state
   always_comb begin
      nxt_state = state;
      if (!act) begin
         nxt_state = UP_IDLE;
      end else begin
         case (state)
            UP_IDLE:  if (io.ioctl_rd && in_range) nxt_state = UP_PEND;
            UP_PEND:  if (ce_ref)                  nxt_state = UP_FETCH;
            UP_FETCH: if (done)                    nxt_state = UP_IDLE;
            default:                               nxt_state = UP_IDLE;
         endcase
      end
   end

   // Decoded per-cycle actions; a ce_ref coincident with the request is skipped
   // because issue is only taken from PEND
   always_comb begin
      accept  = (state == UP_IDLE) & rd_req & in_range;
      reject  = (state == UP_IDLE) & rd_req & ~in_range;
      issue   = act & (state == UP_PEND) & ce_ref;
      run     = (state == UP_FETCH);
      finish  = act & done;
      abort   = ~act & (state != UP_IDLE);
      overlap = rd_req & (state != UP_IDLE);
   end

   // Session tracking: hold the core in reset and latch the bank at session start
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         hold_reset  <= 1'b0;
         io.ram_bank <= 2'd0;
      end else begin
         hold_reset <= act;
         if (act_rise)
            io.ram_bank <= bank_sel;
      end
   end

   // SDRAM request and HPS wait/busy handshake; ram_a only moves in IDLE so it
   // is stable for the whole time ram_oe is high
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         io.ram_a      <= 23'd0;
         io.ram_oe     <= 1'b0;
         io.ioctl_wait <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (accept) begin
            io.ram_a      <= RAM_BASE + 23'(io.ioctl_addr[SIZE_LOG2-1:0]);
            io.ioctl_wait <= 1'b1;
            busy          <= 1'b1;
         end
         if (issue)
            io.ram_oe <= 1'b1;
         if (finish || abort) begin
            io.ram_oe     <= 1'b0;
            io.ioctl_wait <= 1'b0;
            busy          <= 1'b0;
         end
      end
   end

   // Returned byte and running checksum; out-of-range offsets read as erased flash
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         io.ioctl_din <= 8'hFF;
         sum          <= 8'd0;
      end else begin
         if (reject)
            io.ioctl_din <= 8'hFF;
         if (finish) begin
            io.ioctl_din <= io.ram_dout;
            sum          <= sum + io.ram_dout;
         end
         if (act_rise)
            sum <= 8'd0;
      end
   end

   // Sticky protocol error: a request arrived while a fetch was still in flight
   always_ff @(posedge clk_sys) begin
      if (reset)
         err <= 1'b0;
      else if (act_rise)
         err <= 1'b0;
      else if (overlap)
         err <= 1'b1;
   end

endmodule

// File: tb/tb_ram_upload.sv
// Randomised upload bench with an SDRAM model, reference model and scoreboard.
// Latency: reads are checked whenever ioctl_wait releases after a request.
// Backpressure: stimulus waits on ioctl_wait before the next request except where overlap is intended.
module tb_ram_upload;
   import cpc_io_pkg::*;

   localparam int          LAT_REFS  = 2;
   localparam int          SIZE_LOG2 = 17;
   localparam logic [22:0] RAM_BASE  = 23'h200000;
   localparam int          MAX_LAT   = 16 * (LAT_REFS + 1) + 1;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       ce_ref  = 1'b0;
   logic [1:0] bank_sel = 2'd0;
   logic       hold_reset, busy, err;
   logic [7:0] sum;

   ram_upload_if bus ();

   ram_upload #(
      .UP_INDEX  (8'd1),
      .RAM_BASE  (RAM_BASE),
      .SIZE_LOG2 (SIZE_LOG2),
      .LAT_REFS  (LAT_REFS)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ce_ref     (ce_ref),
      .io         (bus),
      .bank_sel   (bank_sel),
      .hold_reset (hold_reset),
      .busy       (busy),
      .err        (err),
      .sum        (sum)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Clock; ce_ref changes just before the falling edge, one clk_sys in 16
   initial forever begin
      #5 clk_sys = 1'b1;
      #4 cyc++;
      ce_ref = (cyc % 16 == 0);
      #1 clk_sys = 1'b0;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mem [int unsigned];
   logic [7:0] exp_q [$];
   int         m_sum = 0;
   logic [7:0] m_din = 8'hFF;

   function automatic logic [7:0] mem_rd(input logic [22:0] a);
      int unsigned k;
      k = 32'(a);
      if (mem.exists(k)) return mem[k];
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   // Byte the HPS must see for an upload offset
   function automatic logic [7:0] model_byte(input logic [24:0] off);
      int unsigned o;
      o = 32'(off);
      if (o >= (1 << SIZE_LOG2)) return 8'hFF;
      return mem_rd(23'(32'(RAM_BASE) + o));
   endfunction

   // SDRAM model: returns the byte at the current address
   always @(negedge clk_sys) bus.ram_dout = mem_rd(bus.ram_a);

   // ---------------- SDRAM port monitor ----------------
   int          oe_pulses = 0;
   int          oe_len = 0;
   int          last_oe_len = 0;
   logic [22:0] oe_addr = '0;
   logic [22:0] last_oe_addr = '0;

   initial forever begin
      @(posedge clk_sys);
      #1;
      if (bus.ram_oe) begin
         if (oe_len == 0) begin
            oe_pulses++;
            oe_addr = bus.ram_a;
         end else begin
            chk("ram_a stable during ram_oe", 32'(bus.ram_a), 32'(oe_addr));
         end
         oe_len++;
      end else if (oe_len != 0) begin
         last_oe_len  = oe_len;
         last_oe_addr = oe_addr;
         oe_len = 0;
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      int n;
      forever begin
         @(posedge clk_sys);
         #1;
         if (!reset && bus.ioctl_rd && bus.ioctl_upload && bus.ioctl_index == 8'd1) begin
            n = 0;
            while (bus.ioctl_wait && n < 200) begin
               @(posedge clk_sys);
               #1;
               n++;
            end
            if (bus.ioctl_wait) begin
               checks++;
               errors++;
               $display("FAIL sb wait release: got wait stuck high required low");
            end else if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb underflow: got din %0h required no response", bus.ioctl_din);
            end else begin
               chk("sb ioctl_din", 32'(bus.ioctl_din), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic start_session(input logic [1:0] bank);
      bus.ioctl_upload = 1'b0;
      tick();
      bank_sel         = bank;
      bus.ioctl_index  = 8'd1;
      bus.ioctl_upload = 1'b1;
      tick();
      m_sum = 0;
   endtask

   task automatic do_read(input logic [24:0] off, output int lat);
      logic [7:0] b;
      logic       inr;
      b   = model_byte(off);
      inr = (32'(off) < (1 << SIZE_LOG2));
      exp_q.push_back(b);
      if (inr) m_sum = (m_sum + int'(b)) % 256;
      m_din = b;
      bus.ioctl_addr = off;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
      chk("wait after rd", 32'(bus.ioctl_wait), 32'(inr));
      lat = 1;
      while (bus.ioctl_wait && lat < 200) begin
         tick();
         lat++;
      end
      chk("wait released", 32'(bus.ioctl_wait), 32'd0);
      chk("sum", 32'(sum), 32'(m_sum));
   endtask

   initial begin
      int lat, p, n;
      logic [24:0] off;
      logic [7:0]  first_b;

      bus.ioctl_upload = 1'b0;
      bus.ioctl_index  = 8'd0;
      bus.ioctl_rd     = 1'b0;
      bus.ioctl_addr   = '0;
      mem[32'h200000] = 8'hA5;
      mem[32'h200010] = 8'h80;
      mem[32'h200011] = 8'h80;
      mem[32'h200012] = 8'h01;
      mem[32'h200013] = 8'hFF;

      // reset values
      reset = 1'b1;
      tick(3);
      chk("rst ioctl_din", 32'(bus.ioctl_din), 32'hFF);
      chk("rst ioctl_wait", 32'(bus.ioctl_wait), 0);
      chk("rst ram_oe", 32'(bus.ram_oe), 0);
      chk("rst ram_a", 32'(bus.ram_a), 0);
      chk("rst ram_bank", 32'(bus.ram_bank), 0);
      chk("rst hold_reset", 32'(hold_reset), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst err", 32'(err), 0);
      chk("rst sum", 32'(sum), 0);
      reset = 1'b0;
      tick();

      // basic read of offset 0
      start_session(2'd2);
      chk("hold_reset in session", 32'(hold_reset), 1);
      chk("ram_bank latched", 32'(bus.ram_bank), 2);
      p = oe_pulses;
      do_read(25'h0, lat);
      tick(2);
      chk("one sdram read", 32'(oe_pulses), 32'(p + 1));
      chk("ram_oe length", 32'(last_oe_len), 32'(16 * LAT_REFS));
      chk("ram_a offset 0", 32'(last_oe_addr), 32'h200000);
      chk("din A5", 32'(bus.ioctl_din), 32'hA5);
      chk("sum A5", 32'(sum), 32'hA5);
      chk("latency bound", 32'(lat <= MAX_LAT), 1);

      // range boundary
      do_read(25'h1FFFF, lat);
      tick(2);
      chk("ram_a last byte", 32'(last_oe_addr), 32'h21FFFF);
      p = oe_pulses;
      do_read(25'h20000, lat);
      tick(20);
      chk("no sdram read out of range", 32'(oe_pulses), 32'(p));
      chk("din FF out of range", 32'(bus.ioctl_din), 32'hFF);

      // checksum wrap and clearing at session start
      start_session(2'd1);
      for (int i = 0; i < 4; i++) do_read(25'(32'h10 + i), lat);
      chk("sum wraps to 0", 32'(sum), 32'h00);
      do_read(25'h0, lat);
      start_session(2'd1);
      chk("sum cleared at session", 32'(sum), 0);

      // overlapping request
      p = oe_pulses;
      first_b = model_byte(25'h20);
      exp_q.push_back(first_b);
      m_sum = (m_sum + int'(first_b)) % 256;
      m_din = first_b;
      bus.ioctl_addr = 25'h20;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
      tick(2);
      bus.ioctl_addr = 25'h30;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
      n = 0;
      while (bus.ioctl_wait && n < 200) begin tick(); n++; end
      tick(2);
      chk("err sticky", 32'(err), 1);
      chk("overlap one sdram read", 32'(oe_pulses), 32'(p + 1));
      chk("overlap din first byte", 32'(bus.ioctl_din), 32'(first_b));
      chk("overlap sum", 32'(sum), 32'(m_sum));
      tick(10);
      chk("err still set", 32'(err), 1);
      start_session(2'd3);
      chk("err cleared at session", 32'(err), 0);

      // randomised reads
      for (int i = 0; i < 24; i++) begin
         off = 25'($urandom);
         if ($urandom_range(0, 3) != 0) off = off & 25'h1FFFF;
         else if (off < 25'h20000)      off = off | 25'h20000;
         tick($urandom_range(0, 20));
         do_read(off, lat);
         chk("random latency bound", 32'(lat <= MAX_LAT), 1);
      end

      // session dropped mid-fetch
      exp_q.push_back(m_din);
      bus.ioctl_addr = 25'h40;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
      n = 0;
      while (!bus.ram_oe && n < 100) begin tick(); n++; end
      tick(3);
      bus.ioctl_upload = 1'b0;
      #1;
      chk("hold_reset lags act", 32'(hold_reset), 1);
      tick();
      chk("abort ram_oe", 32'(bus.ram_oe), 0);
      chk("abort wait", 32'(bus.ioctl_wait), 0);
      chk("abort busy", 32'(busy), 0);
      chk("abort hold_reset", 32'(hold_reset), 0);
      chk("abort din kept", 32'(bus.ioctl_din), 32'(m_din));
      chk("abort sum kept", 32'(sum), 32'(m_sum));

      // reset while waiting for an SDRAM slot
      start_session(2'd0);
      n = 0;
      while (!ce_ref && n < 40) begin tick(); n++; end
      tick();
      exp_q.push_back(8'hFF);
      bus.ioctl_addr = 25'h50;
      bus.ioctl_rd   = 1'b1;
      tick();
      bus.ioctl_rd   = 1'b0;
      chk("pend wait high", 32'(bus.ioctl_wait), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_sum = 0;
      m_din = 8'hFF;
      p = oe_pulses;
      chk("pend rst din", 32'(bus.ioctl_din), 32'hFF);
      chk("pend rst wait", 32'(bus.ioctl_wait), 0);
      chk("pend rst ram_oe", 32'(bus.ram_oe), 0);
      chk("pend rst busy", 32'(busy), 0);
      chk("pend rst sum", 32'(sum), 0);
      chk("pend rst hold_reset", 32'(hold_reset), 0);
      chk("pend rst ram_a", 32'(bus.ram_a), 0);
      tick(60);
      chk("no ram_oe after reset", 32'(oe_pulses), 32'(p));
      chk("hold_reset resumes", 32'(hold_reset), 1);

      tick(5);
      chk("scoreboard drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
